// File: rtl/multi_lane_upsp_dispatcher.sv
// multi_lane_upsp_dispatcher: round-robin fan-out of one pixel stream to N_LANES upsampling PEs with in-order result gather; UPSP_PERF_CNT_EN enables the stall counters
module multi_lane_upsp_dispatcher #(
  parameter int N_LANES        = 4,
  parameter int PIX_WIDTH      = 24,
  parameter int OUT_WIDTH      = 24,
  parameter int SRC_IMG_WIDTH  = 960,
  parameter int SRC_IMG_HEIGHT = 540,
  parameter int OUT_PER_IN     = 16,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           abort,
  output logic                           busy,
  output logic                           done,
  output logic                           err_tlast,
  output logic [CNT_WIDTH-1:0]           in_cnt,
  output logic [CNT_WIDTH-1:0]           in_stall_cnt,
  output logic [CNT_WIDTH-1:0]           out_stall_cnt,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic [PIX_WIDTH-1:0]           s_axis_tdata,
  input  logic                           s_axis_tlast,
  output logic [N_LANES-1:0]             lane_rvalid,
  input  logic [N_LANES-1:0]             lane_rready,
  output logic [PIX_WIDTH-1:0]           lane_rdata,
  input  logic [N_LANES-1:0]             lane_wvalid,
  output logic [N_LANES-1:0]             lane_wready,
  input  logic [N_LANES*OUT_WIDTH-1:0]   lane_wdata,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic [OUT_WIDTH-1:0]           m_axis_tdata,
  output logic                           m_axis_tlast
);
  localparam int IN_TOTAL  = SRC_IMG_WIDTH * SRC_IMG_HEIGHT;
  localparam int OUT_TOTAL = IN_TOTAL * OUT_PER_IN;
  localparam int PW = N_LANES > 1 ? $clog2(N_LANES) : 1;
  localparam int WW = $clog2(OUT_PER_IN) + 1;
  localparam logic [PW-1:0]        LAST_LANE = PW'(N_LANES - 1);
  localparam logic [WW-1:0]        W_LAST    = WW'(OUT_PER_IN - 1);
  localparam logic [CNT_WIDTH-1:0] IN_LAST   = CNT_WIDTH'(IN_TOTAL - 1);
  localparam logic [CNT_WIDTH-1:0] OUT_LAST  = CNT_WIDTH'(OUT_TOTAL - 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [PW-1:0] in_ptr, out_ptr;
  logic [WW-1:0] wcnt;
  logic [CNT_WIDTH-1:0] out_cnt;
  logic out_fin, active, go, kill, in_hs, in_last, ld, out_last;
  assign active        = state == RUN || state == DRAIN;
  assign go            = state == IDLE && start;
  assign kill          = active && abort;
  assign busy          = active;
  assign done          = state == DONE;
  assign s_axis_tready = state == RUN && lane_rready[in_ptr];
  assign lane_rvalid   = (state == RUN && s_axis_tvalid) ? N_LANES'(1) << in_ptr : '0;
  assign lane_rdata    = s_axis_tdata;
  assign lane_wready   = (active && (!m_axis_tvalid || m_axis_tready)) ? N_LANES'(1) << out_ptr : '0;
  assign in_hs         = s_axis_tvalid && s_axis_tready;
  assign in_last       = in_hs && in_cnt == IN_LAST;
  assign ld            = |(lane_wvalid & lane_wready);
  assign out_last      = m_axis_tvalid && m_axis_tready && m_axis_tlast;
  // frame sequencing; abort outranks the count-driven transitions, and an early final output lets RUN skip DRAIN
  always_comb begin
    state_nx = go ? RUN
             : kill ? IDLE
             : (state == RUN && in_last) ? ((out_fin || out_last) ? DONE : DRAIN)
             : (state == DRAIN && out_last) ? DONE
             : (state == DONE) ? IDLE
             : state;
  end
  // pointers, counters, tlast check and the single-stage output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      in_ptr        <= '0;
      out_ptr       <= '0;
      wcnt          <= '0;
      in_cnt        <= '0;
      out_cnt       <= '0;
      out_fin       <= 1'b0;
      err_tlast     <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
    end else begin
      state <= state_nx;
      if (go) begin
        in_ptr    <= '0;
        out_ptr   <= '0;
        wcnt      <= '0;
        in_cnt    <= '0;
        out_cnt   <= '0;
        out_fin   <= 1'b0;
        err_tlast <= 1'b0;
      end else if (kill) begin
        in_ptr        <= '0;
        out_ptr       <= '0;
        wcnt          <= '0;
        m_axis_tvalid <= 1'b0;
      end else begin
        if (in_hs) begin
          in_ptr    <= in_ptr == LAST_LANE ? '0 : in_ptr + 1'b1;
          in_cnt    <= &in_cnt ? in_cnt : in_cnt + 1'b1;
          err_tlast <= err_tlast | (s_axis_tlast != (in_cnt == IN_LAST));
        end
        if (ld) begin
          wcnt          <= wcnt == W_LAST ? '0 : wcnt + 1'b1;
          out_ptr       <= wcnt != W_LAST ? out_ptr : out_ptr == LAST_LANE ? '0 : out_ptr + 1'b1;
          out_cnt       <= out_cnt + 1'b1;
          m_axis_tdata  <= lane_wdata[out_ptr*OUT_WIDTH +: OUT_WIDTH];
          m_axis_tlast  <= out_cnt == OUT_LAST;
          m_axis_tvalid <= 1'b1;
        end else if (m_axis_tready) begin
          m_axis_tvalid <= 1'b0;
        end
        if (out_last) out_fin <= 1'b1;
      end
    end
  end
`ifdef UPSP_PERF_CNT_EN
  // saturating stall counters, cleared as a frame starts
  always_ff @(posedge clk) begin
    if (rst || go) begin
      in_stall_cnt  <= '0;
      out_stall_cnt <= '0;
    end else begin
      if (state == RUN && s_axis_tvalid && !s_axis_tready && !(&in_stall_cnt)) in_stall_cnt <= in_stall_cnt + 1'b1;
      if (m_axis_tvalid && !m_axis_tready && !(&out_stall_cnt)) out_stall_cnt <= out_stall_cnt + 1'b1;
    end
  end
`else
  assign in_stall_cnt  = '0;
  assign out_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_multi_lane_upsp_dispatcher.sv
// tb_multi_lane_upsp_dispatcher: scoreboard bench with echo PE lanes for multi_lane_upsp_dispatcher
module tb_multi_lane_upsp_dispatcher;
  localparam int NL = 4, PWD = 24, OWD = 24, CW = 32, OPI = 2, NIN = 16, NOUT = NIN * OPI;
  logic clk = 1'b0;
  logic rst, start, abort, busy, done, err_tlast;
  logic [CW-1:0] in_cnt, in_stall_cnt, out_stall_cnt;
  logic s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [PWD-1:0] s_axis_tdata, lane_rdata;
  logic [NL-1:0] lane_rvalid, lane_rready, lane_wvalid, lane_wready;
  logic [NL*OWD-1:0] lane_wdata;
  logic m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [OWD-1:0] m_axis_tdata;
  always #5 clk = ~clk;
  multi_lane_upsp_dispatcher #(
    .N_LANES(NL), .PIX_WIDTH(PWD), .OUT_WIDTH(OWD), .SRC_IMG_WIDTH(8),
    .SRC_IMG_HEIGHT(2), .OUT_PER_IN(OPI), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .err_tlast(err_tlast), .in_cnt(in_cnt), .in_stall_cnt(in_stall_cnt), .out_stall_cnt(out_stall_cnt),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .s_axis_tlast(s_axis_tlast), .lane_rvalid(lane_rvalid), .lane_rready(lane_rready),
    .lane_rdata(lane_rdata), .lane_wvalid(lane_wvalid), .lane_wready(lane_wready),
    .lane_wdata(lane_wdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast)
  );
  int checks = 0, errors = 0;
  logic [OWD-1:0] exp_q[$];
  logic [PWD-1:0] lbuf[NL][16];
  int lhead[NL], ltail[NL], lk[NL];
  int src_i, tlast_pos, abort_at, stall2, rdy_pct, rst_out, out_n, done_cnt, exp_stall, exp_in_stall;
  bit aborted, rsted, chk_on, spam, start_req, exp_err, rst_chk;
  logic [PWD-1:0] base;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cycle();
    @(negedge clk);
    rst = 1'b0;
    rst_chk = 1'b0;
    if (rst_out > 0 && !rsted && src_i == NIN && out_n >= rst_out && out_n < NOUT) begin
      rst = 1'b1;
      rsted = 1'b1;
      rst_chk = 1'b1;
    end
    abort = 1'b0;
    if (!aborted && src_i == abort_at) begin
      abort = 1'b1;
      aborted = 1'b1;
    end
    start = start_req || (spam && chk_on && src_i < NIN);
    start_req = 1'b0;
    s_axis_tvalid = !aborted && src_i < NIN;
    s_axis_tdata = base + PWD'(src_i);
    s_axis_tlast = src_i == tlast_pos;
    for (int i = 0; i < NL; i++) begin
      lane_rready[i] = (ltail[i] - lhead[i] < 4) && !(i == 2 && stall2 > 0);
      lane_wvalid[i] = ltail[i] != lhead[i];
      lane_wdata[i*OWD +: OWD] = lbuf[i][lhead[i] % 16] + OWD'(lk[i]);
    end
    m_axis_tready = $urandom_range(99) < rdy_pct;
    #1;
    if (rst_chk) check("busy_drain", busy, 1);
    if (chk_on) check("err_tlast", err_tlast, exp_err);
    if (stall2 > 0 && lane_rvalid[2]) check("tready_lane2_stall", s_axis_tready, 0);
    if (stall2 > 0) stall2--;
    if (m_axis_tvalid) begin
      if (exp_q.size() == 0) check("m_extra", 1, 0);
      else check("m_data", m_axis_tdata, exp_q[0]);
      if (!m_axis_tready) exp_stall++;
      else begin
        check("m_last", m_axis_tlast, out_n == NOUT - 1);
        out_n++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
    if (chk_on && s_axis_tvalid && !s_axis_tready) exp_in_stall++;
    if (s_axis_tvalid && s_axis_tready) begin
      exp_q.push_back(s_axis_tdata);
      exp_q.push_back(s_axis_tdata + 1'b1);
      if (s_axis_tlast != (src_i == NIN - 1)) exp_err = 1'b1;
      src_i++;
    end
    for (int i = 0; i < NL; i++) begin
      if (lane_rvalid[i] && lane_rready[i]) begin
        lbuf[i][ltail[i] % 16] = lane_rdata;
        ltail[i]++;
      end
      if (lane_wvalid[i] && lane_wready[i]) begin
        lk[i]++;
        if (lk[i] == OPI) begin
          lk[i] = 0;
          lhead[i]++;
        end
      end
    end
    if (done) done_cnt++;
  endtask
  task automatic frame(input int tl, input int ab, input int st2, input int pct,
                       input bit spam_en, input int rst_o, input logic [PWD-1:0] b);
    src_i = 0; out_n = 0; done_cnt = 0; exp_stall = 0; exp_in_stall = 0;
    exp_err = 0; aborted = 0; rsted = 0; chk_on = 0;
    tlast_pos = tl; abort_at = ab; stall2 = st2; rdy_pct = pct; spam = spam_en; rst_out = rst_o; base = b;
    exp_q.delete();
    for (int i = 0; i < NL; i++) begin
      lhead[i] = 0; ltail[i] = 0; lk[i] = 0;
    end
    start_req = 1'b1;
    cycle();
    chk_on = 1'b1;
    cycle();
    check("busy_run", busy, 1);
    for (int c = 0; c < 3000 && done_cnt == 0 && !aborted && !rsted; c++) cycle();
    chk_on = 1'b0;
    cycle();
    if (aborted) begin
      check("abort_busy", busy, 0);
      check("abort_in_cnt", in_cnt, ab);
      check("abort_done", done_cnt, 0);
      check("abort_mvalid", m_axis_tvalid, 0);
    end else if (rsted) begin
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err_tlast, 0);
      check("rst_mvalid", m_axis_tvalid, 0);
      check("rst_mlast", m_axis_tlast, 0);
      check("rst_sready", s_axis_tready, 0);
      check("rst_rvalid", lane_rvalid, 0);
      check("rst_wready", lane_wready, 0);
      check("rst_in_cnt", in_cnt, 0);
    end else if (done_cnt == 0) begin
      check("frame_timeout", 0, 1);
    end else begin
      check("done_pulses", done_cnt, 1);
      check("end_busy", busy, 0);
      check("end_in_cnt", in_cnt, NIN);
      check("end_out_words", out_n, NOUT);
      check("end_sb_empty", exp_q.size(), 0);
      check("end_err_tlast", err_tlast, exp_err);
`ifdef UPSP_PERF_CNT_EN
      check("out_stall_cnt", out_stall_cnt, exp_stall);
      check("in_stall_cnt", in_stall_cnt, exp_in_stall);
`else
      check("out_stall_tie", out_stall_cnt, 0);
      check("in_stall_tie", in_stall_cnt, 0);
`endif
    end
  endtask
  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
    lane_rready = '0; lane_wvalid = '0; lane_wdata = '0; m_axis_tready = 1'b0;
    start_req = 1'b0; spam = 1'b0; chk_on = 1'b0; aborted = 1'b0; rsted = 1'b0;
    src_i = NIN; abort_at = -1; tlast_pos = -1; stall2 = 0; rdy_pct = 100; rst_out = 0; base = '0;
    for (int i = 0; i < NL; i++) begin
      lhead[i] = 0; ltail[i] = 0; lk[i] = 0;
    end
    repeat (3) @(negedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err_tlast, 0);
    check("reset_mvalid", m_axis_tvalid, 0);
    check("reset_mlast", m_axis_tlast, 0);
    check("reset_sready", s_axis_tready, 0);
    check("reset_rvalid", lane_rvalid, 0);
    check("reset_wready", lane_wready, 0);
    check("reset_in_cnt", in_cnt, 0);
    frame(15, -1, 0, 100, 1'b0, 0, 24'h001000);
    frame(15, -1, 10, 100, 1'b0, 0, 24'h002000);
    frame(15, -1, 0, 30, 1'b0, 0, 24'h003000);
    frame(9, -1, 0, 100, 1'b0, 0, 24'h004000);
    frame(15, 7, 0, 100, 1'b0, 0, 24'h005000);
    frame(15, -1, 0, 100, 1'b0, 0, 24'h006000);
    frame(15, -1, 0, 30, 1'b1, 8, 24'h007000);
    frame(15, -1, 0, 70, 1'b0, 0, 24'h008000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
